// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor decode/issue path.
// Defines the instruction field layout, opcode values and the issue entry record.
package simple_processor_pkg;

  localparam int DATAWIDTH = 32;
  localparam int REG_AW    = 5;
  localparam int IMM_W     = 6;
  localparam int ILL_CNT_W = 8;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int RD_LSB  = 4;
  localparam int RD_MSB  = 8;
  localparam int RS1_LSB = 9;
  localparam int RS1_MSB = 13;
  localparam int RS2_LSB = 14;
  localparam int RS2_MSB = 18;
  localparam int IMM_LSB = 19;
  localparam int IMM_MSB = 24;

  localparam logic [3:0] OPC_AND  = 4'd0;
  localparam logic [3:0] OPC_OR   = 4'd1;
  localparam logic [3:0] OPC_XOR  = 4'd2;
  localparam logic [3:0] OPC_NOT  = 4'd3;
  localparam logic [3:0] OPC_ADDI = 4'd4;
  localparam logic [3:0] OPC_ADD  = 4'd5;
  localparam logic [3:0] OPC_SUB  = 4'd6;
  localparam logic [3:0] OPC_SLL  = 4'd7;
  localparam logic [3:0] OPC_SLLI = 4'd8;
  localparam logic [3:0] OPC_SLR  = 4'd9;
  localparam logic [3:0] OPC_SLRI = 4'd10;

  typedef enum logic [3:0] {
    FUNC_AND  = 4'd0,
    FUNC_OR   = 4'd1,
    FUNC_XOR  = 4'd2,
    FUNC_NOT  = 4'd3,
    FUNC_ADDI = 4'd4,
    FUNC_ADD  = 4'd5,
    FUNC_SUB  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;

  typedef struct packed {
    func_t                 func;
    logic [IMM_W-1:0]      imm;
    logic [REG_AW-1:0]     rd;
    logic [DATAWIDTH-1:0]  rs1_data;
    logic [DATAWIDTH-1:0]  rs2_data;
  } issue_entry_t;

endpackage

// File: rtl/instr_decode_issue_decoder.sv
// Purely combinational field extraction and opcode decode.
// Opcodes outside the defined set are reported as illegal.
module instr_decoder
  import simple_processor_pkg::*;
(
  input  logic [IMM_MSB:0]    instr_i,
  output func_t               func_o,
  output logic [IMM_W-1:0]    imm_o,
  output logic [REG_AW-1:0]   rd_o,
  output logic [REG_AW-1:0]   rs1_addr_o,
  output logic [REG_AW-1:0]   rs2_addr_o,
  output logic                illegal_o
);

  logic [3:0] opcode_s;

  assign opcode_s   = instr_i[OPC_MSB:OPC_LSB];
  assign imm_o      = instr_i[IMM_MSB:IMM_LSB];
  assign rd_o       = instr_i[RD_MSB:RD_LSB];
  assign rs1_addr_o = instr_i[RS1_MSB:RS1_LSB];
  assign rs2_addr_o = instr_i[RS2_MSB:RS2_LSB];

  // Opcode to function mapping; unmapped opcodes raise the illegal flag.
  always_comb begin
    func_o    = FUNC_AND;
    illegal_o = 1'b0;
    case (opcode_s)
      OPC_AND:  func_o = FUNC_AND;
      OPC_OR:   func_o = FUNC_OR;
      OPC_XOR:  func_o = FUNC_XOR;
      OPC_NOT:  func_o = FUNC_NOT;
      OPC_ADDI: func_o = FUNC_ADDI;
      OPC_ADD:  func_o = FUNC_ADD;
      OPC_SUB:  func_o = FUNC_SUB;
      OPC_SLL:  func_o = FUNC_SLL;
      OPC_SLLI: func_o = FUNC_SLLI;
      OPC_SLR:  func_o = FUNC_SLR;
      OPC_SLRI: func_o = FUNC_SLRI;
      default: begin
        func_o    = FUNC_AND;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_issue.sv
// Decode/issue stage: decodes fetched instructions, captures register operands and
// issues them to the EU through a 2-entry elastic buffer (output reg + skid reg).
module instr_decode_issue
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  flush_i,
  output logic [REG_AW-1:0]     rs1_addr_o,
  output logic [REG_AW-1:0]     rs2_addr_o,
  input  logic [DATAWIDTH-1:0]  rs1_data_i,
  input  logic [DATAWIDTH-1:0]  rs2_data_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output func_t                 func_o,
  output logic [IMM_W-1:0]      imm_o,
  output logic [REG_AW-1:0]     rd_addr_o,
  output logic [DATAWIDTH-1:0]  rs1_data_o,
  output logic [DATAWIDTH-1:0]  rs2_data_o,
  output logic                  illegal_o,
  output logic [ILL_CNT_W-1:0]  ill_count_o
);

  func_t                 dec_func_s;
  logic [IMM_W-1:0]      dec_imm_s;
  logic [REG_AW-1:0]     dec_rd_s;
  logic                  dec_illegal_s;
  logic                  unused_hi_s;

  issue_entry_t          new_entry_s;
  issue_entry_t          out_entry_r, out_entry_n;
  issue_entry_t          skid_entry_r, skid_entry_n;
  logic                  out_valid_r, out_valid_n;
  logic                  skid_valid_r, skid_valid_n;
  logic                  illegal_r, illegal_n;
  logic [ILL_CNT_W-1:0]  ill_cnt_r, ill_cnt_n;

  logic                  accept_s;
  logic                  load_s;
  logic                  out_free_s;

  instr_decoder u_decoder (
    .instr_i    (instr_i[IMM_MSB:0]),
    .func_o     (dec_func_s),
    .imm_o      (dec_imm_s),
    .rd_o       (dec_rd_s),
    .rs1_addr_o (rs1_addr_o),
    .rs2_addr_o (rs2_addr_o),
    .illegal_o  (dec_illegal_s)
  );

  // Bits [31:25] carry no meaning for this ISA.
  assign unused_hi_s = ^instr_i[31:IMM_MSB+1];

  assign new_entry_s = '{func: dec_func_s, imm: dec_imm_s, rd: dec_rd_s,
                         rs1_data: rs1_data_i, rs2_data: rs2_data_i};

  assign instr_ready_o = ~skid_valid_r;
  assign accept_s      = instr_valid_i & ~skid_valid_r & ~flush_i;
  assign load_s        = accept_s & ~dec_illegal_s;
  assign out_free_s    = ~out_valid_r | issue_ready_i;

  // Buffer next state: skid always drains before a new entry may enter the output slot.
  always_comb begin
    out_valid_n  = out_valid_r;
    out_entry_n  = out_entry_r;
    skid_valid_n = skid_valid_r;
    skid_entry_n = skid_entry_r;
    if (flush_i) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_valid_n  = 1'b1;
        out_entry_n  = skid_entry_r;
        skid_valid_n = 1'b0;
      end else if (load_s) begin
        out_valid_n = 1'b1;
        out_entry_n = new_entry_s;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (load_s) begin
      skid_valid_n = 1'b1;
      skid_entry_n = new_entry_s;
    end else begin
      skid_valid_n = skid_valid_r;
    end
  end

  // Illegal pulse and saturating counter next state.
  always_comb begin
    illegal_n = accept_s & dec_illegal_s;
    if (illegal_n && (ill_cnt_r != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_n = ill_cnt_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ill_cnt_n = ill_cnt_r;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_entry_r  <= '0;
      skid_entry_r <= '0;
      illegal_r    <= 1'b0;
      ill_cnt_r    <= {ILL_CNT_W{1'b0}};
    end else begin
      out_valid_r  <= out_valid_n;
      skid_valid_r <= skid_valid_n;
      out_entry_r  <= out_entry_n;
      skid_entry_r <= skid_entry_n;
      illegal_r    <= illegal_n;
      ill_cnt_r    <= ill_cnt_n;
    end
  end

  assign issue_valid_o = out_valid_r;
  assign func_o        = out_entry_r.func;
  assign imm_o         = out_entry_r.imm;
  assign rd_addr_o     = out_entry_r.rd;
  assign rs1_data_o    = out_entry_r.rs1_data;
  assign rs2_data_o    = out_entry_r.rs2_data;
  assign illegal_o     = illegal_r;
  assign ill_count_o   = ill_cnt_r;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Self-checking bench for instr_decode_issue: directed vector table, hand-written
// backpressure/flush/saturation/reset sequences and a randomised run against a queue model.
module tb_instr_decode_issue;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  func_t       func_o;
  logic [5:0]  imm_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        illegal_o;
  logic [7:0]  ill_count_o;
  logic [3:0]  func_s;

  assign func_s = func_o;

  always #5 clk_i = ~clk_i;

  instr_decode_issue dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .flush_i(flush_i), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .func_o(func_o),
    .imm_o(imm_o), .rd_addr_o(rd_addr_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .illegal_o(illegal_o), .ill_count_o(ill_count_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  func;
    logic [5:0]  imm;
    logic [4:0]  rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  func;
    logic [5:0]  imm;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic m_pulse;
  logic cons, acc, legal;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] rd);
    mk_add = {23'd0, rd, 4'd5};
  endfunction

  initial begin
    vecs[0] = '{32'h00008235, 32'd5,        32'd7,        4'd5,  6'h00, 5'd3,  5'd1,  5'd2,  1'b0};
    vecs[1] = '{32'h01F80414, 32'h12345678, 32'h9ABCDEF0, 4'd4,  6'h3F, 5'd1,  5'd2,  5'd0,  1'b0};
    vecs[2] = '{32'hFE07FFF6, 32'hFFFFFFFF, 32'h80000000, 4'd6,  6'h00, 5'd31, 5'd31, 5'd31, 1'b0};
    vecs[3] = '{32'h01502AAA, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd10, 6'h2A, 5'd10, 5'd21, 5'd0,  1'b0};
    vecs[4] = '{32'h0000000F, 32'd1,        32'd2,        4'd0,  6'h00, 5'd0,  5'd0,  5'd0,  1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'hDEADBEEF, 4'd0,  6'h00, 5'd0,  5'd0,  5'd0,  1'b0};
    vecs[6] = '{32'h0000000B, 32'd3,        32'd4,        4'd0,  6'h00, 5'd0,  5'd0,  5'd0,  1'b1};
    vecs[7] = '{32'h00001073, 32'h0000CAFE, 32'h0000BEEF, 4'd3,  6'h00, 5'd7,  5'd8,  5'd0,  1'b0};

    arst_ni = 1'b0; instr_i = 32'd0; instr_valid_i = 1'b0; flush_i = 1'b0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; issue_ready_i = 1'b1;
    #12;
    arst_ni = 1'b1;
    tick();
    chk("rst_issue_valid", {63'd0, issue_valid_o}, 64'd0);
    chk("rst_ready", {63'd0, instr_ready_o}, 64'd1);
    chk("rst_illegal", {63'd0, illegal_o}, 64'd0);
    chk("rst_count", {56'd0, ill_count_o}, 64'd0);
    chk("rst_rd_func", {55'd0, rd_addr_o, func_s}, 64'd0);

    // Directed single-instruction table, empty pipeline, EU always ready.
    for (int i = 0; i < 8; i++) begin
      instr_i = vecs[i].instr; instr_valid_i = 1'b1;
      rs1_data_i = vecs[i].d1; rs2_data_i = vecs[i].d2;
      #1;
      chk("vec_rs1_addr", {59'd0, rs1_addr_o}, {59'd0, vecs[i].a1});
      chk("vec_rs2_addr", {59'd0, rs2_addr_o}, {59'd0, vecs[i].a2});
      tick();
      instr_valid_i = 1'b0; rs1_data_i = 32'h0BADF00D; rs2_data_i = 32'h0BADF00D;
      if (vecs[i].ill) exp_cnt++;
      chk("vec_issue_valid", {63'd0, issue_valid_o}, {63'd0, ~vecs[i].ill});
      chk("vec_illegal", {63'd0, illegal_o}, {63'd0, vecs[i].ill});
      chk("vec_count", {56'd0, ill_count_o}, 64'(exp_cnt));
      if (!vecs[i].ill) begin
        chk("vec_func", {60'd0, func_s}, {60'd0, vecs[i].func});
        chk("vec_imm", {58'd0, imm_o}, {58'd0, vecs[i].imm});
        chk("vec_rd", {59'd0, rd_addr_o}, {59'd0, vecs[i].rd});
        chk("vec_ops", {rs1_data_o, rs2_data_o}, {vecs[i].d1, vecs[i].d2});
      end
      tick();
      chk("vec_drained", {62'd0, issue_valid_o, illegal_o}, 64'd0);
    end

    // Backpressure: three instructions while the EU stalls, then release.
    issue_ready_i = 1'b0; instr_valid_i = 1'b1;
    instr_i = mk_add(5'd1); rs1_data_i = 32'h11;
    tick();
    chk("bp_first_rd", {59'd0, rd_addr_o}, 64'd1);
    chk("bp_ready1", {63'd0, instr_ready_o}, 64'd1);
    instr_i = mk_add(5'd2); rs1_data_i = 32'h22;
    tick();
    chk("bp_ready2", {63'd0, instr_ready_o}, 64'd0);
    chk("bp_hold_rd", {59'd0, rd_addr_o}, 64'd1);
    instr_i = mk_add(5'd3); rs1_data_i = 32'h33;
    tick();
    chk("bp_stall_rd", {59'd0, rd_addr_o}, 64'd1);
    chk("bp_stall_op", {32'd0, rs1_data_o}, 64'h11);
    chk("bp_stall_ready", {63'd0, instr_ready_o}, 64'd0);
    issue_ready_i = 1'b1;
    tick();
    chk("bp_second_rd", {59'd0, rd_addr_o}, 64'd2);
    chk("bp_second_op", {32'd0, rs1_data_o}, 64'h22);
    chk("bp_ready3", {63'd0, instr_ready_o}, 64'd1);
    tick();
    instr_valid_i = 1'b0;
    chk("bp_third_rd", {59'd0, rd_addr_o}, 64'd3);
    chk("bp_third_op", {32'd0, rs1_data_o}, 64'h33);
    tick();
    chk("bp_empty", {63'd0, issue_valid_o}, 64'd0);

    // Flush with two entries buffered and a concurrent incoming instruction.
    issue_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = mk_add(5'd4);
    tick();
    instr_i = mk_add(5'd5);
    tick();
    chk("fl_full", {62'd0, issue_valid_o, instr_ready_o}, 64'b10);
    instr_i = mk_add(5'd6); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; instr_valid_i = 1'b0;
    chk("fl_valid", {63'd0, issue_valid_o}, 64'd0);
    chk("fl_ready", {63'd0, instr_ready_o}, 64'd1);
    chk("fl_count", {56'd0, ill_count_o}, 64'(exp_cnt));
    issue_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_nothing", {63'd0, issue_valid_o}, 64'd0);
    end

    // Illegal counter saturation.
    instr_i = 32'h0000000F; instr_valid_i = 1'b1;
    tick();
    chk("sat_pulse", {63'd0, illegal_o}, 64'd1);
    chk("sat_no_issue", {63'd0, issue_valid_o}, 64'd0);
    repeat (299) tick();
    chk("sat_count", {56'd0, ill_count_o}, 64'd255);
    instr_valid_i = 1'b0;
    tick();
    chk("sat_pulse_end", {63'd0, illegal_o}, 64'd0);
    chk("sat_hold", {56'd0, ill_count_o}, 64'd255);

    // Asynchronous reset while stalled with a full buffer.
    issue_ready_i = 1'b0; instr_valid_i = 1'b1;
    instr_i = 32'h0FFFFFF5; rs1_data_i = 32'hFFFFFFFF; rs2_data_i = 32'hFFFFFFFF;
    tick();
    tick();
    instr_valid_i = 1'b0;
    #2 arst_ni = 1'b0;
    #1;
    chk("ar_valid", {63'd0, issue_valid_o}, 64'd0);
    chk("ar_fields", {51'd0, func_s, imm_o, rd_addr_o}, 64'd0);
    chk("ar_ops", {rs1_data_o, rs2_data_o}, 64'd0);
    chk("ar_count", {55'd0, illegal_o, ill_count_o}, 64'd0);
    chk("ar_ready", {63'd0, instr_ready_o}, 64'd1);
    @(negedge clk_i);
    arst_ni = 1'b1;
    tick();

    // Randomised traffic against an in-order queue model.
    m_pulse = 1'b0; exp_cnt = 0; q.delete();
    for (int n = 0; n < 5000; n++) begin
      instr_i = $urandom;
      if ($urandom_range(0, 3) != 0) instr_i[3:0] = 4'($urandom_range(0, 10));
      instr_valid_i = ($urandom_range(0, 9) < 7);
      issue_ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 49) == 0);
      rs1_data_i = $urandom; rs2_data_i = $urandom;
      chk("rnd_valid", {63'd0, issue_valid_o}, {63'd0, q.size() != 0});
      chk("rnd_ready", {63'd0, instr_ready_o}, {63'd0, q.size() < 2});
      chk("rnd_illegal", {63'd0, illegal_o}, {63'd0, m_pulse});
      chk("rnd_count", {56'd0, ill_count_o}, 64'(exp_cnt));
      if (q.size() != 0) begin
        chk("rnd_entry", {func_s, imm_o, rd_addr_o, rs1_data_o, rs2_data_o},
            {q[0].func, q[0].imm, q[0].rd, q[0].d1, q[0].d2});
      end
      cons  = (q.size() != 0) && issue_ready_i;
      acc   = instr_valid_i && (q.size() < 2) && !flush_i;
      legal = (instr_i[3:0] <= 4'd10);
      e = '{instr_i[3:0], instr_i[24:19], instr_i[8:4], rs1_data_i, rs2_data_i};
      tick();
      if (flush_i) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc && legal) q.push_back(e);
      end
      m_pulse = acc && !legal;
      if (m_pulse && exp_cnt != 255) exp_cnt++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
